send_mem_fsm: RTL and testbench
===============================

Name: send_mem_fsm

Overview:
- Debug-unit transmit sequencer: the transmit-side counterpart of the instruction loader.
- On a start command it reads a block of 32-bit words from data memory, starting at address 0, and streams them over the UART transmitter.
- Frame sent: one count byte, then each word as 4 bytes, MSB first.
- Sits between the debug-unit top FSM, the data-memory debug read port and the UART TX.

Parameters:
- UART_BITS, `UART_BITS (8), UART character width.
- DATA_ADDRS_BITS, `DATA_ADDRS_BITS (10), data-memory address width; must be >= UART_BITS.
- DATA_BITS, `DATA_BITS (32), memory word width; must equal 4*UART_BITS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- i_start  in  1  one-cycle request to begin a dump; ignored while o_busy=1.
- i_word_count  in  UART_BITS  number of words to send (0..255); sampled when i_start is accepted.
- o_mem_rd  out  1  one-cycle data-memory read strobe.
- o_mem_addr  out  DATA_ADDRS_BITS  read address; held stable from the o_mem_rd cycle until the word is captured.
- i_mem_data  in  DATA_BITS  memory read data; valid on the cycle after the o_mem_rd cycle.
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
- o_tx_data  out  UART_BITS  byte to send; held stable from o_tx_start until i_tx_done.
- i_tx_done  in  1  one-cycle pulse from the UART when the current byte has finished.
- o_busy  out  1  high from the accepted start until o_done.
- o_done  out  1  one-cycle pulse when the full frame has been sent.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, rst=1): state IDLE; all outputs and internal counters go to 0 immediately, without waiting for clk.
- States: IDLE, SEND_COUNT, WAIT_COUNT, READ_MEM, CAPTURE, SEND_BYTE, WAIT_BYTE, FINISH.
- IDLE:
  - i_start=1 at an edge → latch word_count, clear addr and byte_idx, go to SEND_COUNT.
  - o_busy=1 from the next cycle.
- SEND_COUNT: o_tx_start=1 for exactly one cycle with o_tx_data=word_count → WAIT_COUNT.
- WAIT_COUNT: hold o_tx_data; on i_tx_done → READ_MEM if word_count != 0, else FINISH.
- READ_MEM: o_mem_rd=1 for one cycle with o_mem_addr=addr → CAPTURE.
- CAPTURE: at the end of this cycle, latch i_mem_data into the shift register; byte_idx=0 → SEND_BYTE.
- SEND_BYTE: o_tx_start=1 for one cycle; o_tx_data = shift register top byte (bits DATA_BITS-1 : DATA_BITS-UART_BITS) → WAIT_BYTE.
- WAIT_BYTE: on i_tx_done, shift the register left by UART_BITS and increment byte_idx.
  - byte_idx was 3: increment addr, decrement word_count; → READ_MEM if the new word_count != 0, else FINISH.
  - Otherwise → SEND_BYTE.
- FINISH: o_done=1 for one cycle, o_busy=0 → IDLE.
- Latency:
  - i_start accepted to first o_tx_start: 1 cycle.
  - i_tx_done to next o_tx_start: 1 cycle within a word; 3 cycles across a word boundary (READ_MEM, CAPTURE, SEND_BYTE).
- Boundary conditions:
  - i_tx_done outside WAIT_COUNT/WAIT_BYTE: ignored.
  - i_start while busy: ignored; changes to i_word_count mid-dump have no effect.
  - word_count=0: frame is the single byte 0x00, then o_done; no memory read is issued.
  - word_count=255: addresses 0..254; addr is zero-extended UART_BITS→DATA_ADDRS_BITS and never wraps.
  - i_tx_done and i_start in the same IDLE cycle: start is accepted, the stray done is ignored.
  - Reset mid-frame: FSM aborts to IDLE. The byte already in the UART completes (UART-owned); no further o_tx_start is issued.
- Arithmetic: addr is DATA_ADDRS_BITS wide; word_count and byte_idx (2 bits) wrap modulo their width, but the FSM never lets them wrap.

Decomposition:
- constants.vh holds:
  - UART_BITS, DATA_BITS, DATA_ADDRS_BITS.
  - Debug frame constants: BYTES_PER_WORD=4, COUNT_BYTE_BITS=8.
- State localparams stay local to the module.
- One sub-module is natural: tx_byte_serializer, a DATA_BITS→UART_BITS MSB-first shift register with load/shift/byte_idx and last-byte flag, reusable for register-file dumps.

Test Plan:
- Reset mid-transfer: assert rst asynchronously between clk edges during WAIT_BYTE → all outputs 0 before the next edge; no further o_tx_start; a new i_start works normally.
- Zero count: i_word_count=0, i_start, TX model returns i_tx_done 10 cycles after each start → exactly one byte 0x00 sent, no o_mem_rd, o_done one cycle after i_tx_done.
- Two words: mem[0]=0xDEADBEEF, mem[1]=0x01234567, count=2 → bytes 0x02,DE,AD,BE,EF,01,23,45,67 in order; o_mem_addr 0 then 1; one o_done; o_busy high throughout.
- Handshake timing: i_tx_done held back for 50 cycles → o_tx_data stable and no second o_tx_start until 1 cycle after i_tx_done; cross-word gap is exactly 3 cycles.
- Spurious inputs: pulse i_tx_done in IDLE and during READ_MEM, pulse i_start mid-frame with a different count → frame unchanged and byte count unchanged.
- Max count: count=255 with mem[a]=a → 1+1020 bytes; last word 0x000000FE; final o_mem_addr=254; o_done once.

Source files
------------

// File: rtl/send_mem_fsm_pkg.sv
// send_mem_fsm_pkg
// Shared constants and types for the debug-unit transmit sequencer.
// Defines the UART character width, the data-memory geometry, the debug
// frame constants and the sequencer state encoding.

package send_mem_fsm_pkg;

    // UART character width and data-memory geometry
    localparam int UART_BITS       = 8;
    localparam int DATA_ADDRS_BITS = 10;
    localparam int DATA_BITS       = 32;

    // Debug frame layout: one count byte, then each word as four bytes
    localparam int BYTES_PER_WORD  = 4;
    localparam int COUNT_BYTE_BITS = 8;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE,
        SEND_COUNT,
        WAIT_COUNT,
        READ_MEM,
        CAPTURE,
        SEND_BYTE,
        WAIT_BYTE,
        FINISH
    } state_t;

endpackage

// File: rtl/send_mem_fsm_serializer.sv
// send_mem_fsm_serializer
// Word-to-byte serializer: holds one DATA_BITS word and hands it out
// UART_BITS at a time, most significant byte first. Reusable for any
// word dump (data memory, register file).
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   clear       zero the byte index (start of a new frame)
//   load        capture load_data and restart at byte 0
//   load_data   word to serialize
//   shift       advance to the next byte
//   next_byte   byte that will be on top after the next shift
//   last_byte   the byte currently on top is the final byte of the word

module send_mem_fsm_serializer
    import send_mem_fsm_pkg::*;
#(
    parameter int DATA_BITS = send_mem_fsm_pkg::DATA_BITS,
    parameter int UART_BITS = send_mem_fsm_pkg::UART_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 shift,
    output logic [UART_BITS-1:0] next_byte,
    output logic                 last_byte
);

    logic [DATA_BITS-1:0] shreg;
    logic [1:0]           byte_idx;

    // Shift register and byte index. The shift rotates rather than fills
    // with zeros: the outgoing byte is never observed again before the next
    // load, and rotating keeps every stored bit in use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (load) begin
            shreg    <= load_data;
            byte_idx <= '0;
        end else if (shift) begin
            shreg    <= {shreg[DATA_BITS-UART_BITS-1:0], shreg[DATA_BITS-1 -: UART_BITS]};
            byte_idx <= byte_idx + 2'd1;
        end else if (clear) begin
            byte_idx <= '0;
        end
    end

    // The lookahead byte lets the owner register the next character in the
    // same cycle the shift happens.
    assign next_byte = shreg[DATA_BITS-UART_BITS-1 -: UART_BITS];
    assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/send_mem_fsm.sv
// send_mem_fsm
// Debug-unit transmit sequencer. On a start command it sends a count byte,
// then reads word_count words from data memory starting at address 0 and
// sends each as four bytes, MSB first, through the UART transmitter.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   i_start       one-cycle dump request (ignored while busy)
//   i_word_count  number of words to send, sampled on an accepted start
//   o_mem_rd      one-cycle memory read strobe
//   o_mem_addr    read address, held until the word is captured
//   i_mem_data    memory data, valid the cycle after o_mem_rd
//   o_tx_start    one-cycle UART transmit request
//   o_tx_data     byte to transmit, held until i_tx_done
//   i_tx_done     UART finished the current byte
//   o_busy        dump in progress
//   o_done        one-cycle pulse when the frame is complete

module send_mem_fsm
    import send_mem_fsm_pkg::*;
#(
    parameter int UART_BITS       = send_mem_fsm_pkg::UART_BITS,
    parameter int DATA_ADDRS_BITS = send_mem_fsm_pkg::DATA_ADDRS_BITS,
    parameter int DATA_BITS       = send_mem_fsm_pkg::DATA_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [UART_BITS-1:0]       i_word_count,
    output logic                       o_mem_rd,
    output logic [DATA_ADDRS_BITS-1:0] o_mem_addr,
    input  logic [DATA_BITS-1:0]       i_mem_data,
    output logic                       o_tx_start,
    output logic [UART_BITS-1:0]       o_tx_data,
    input  logic                       i_tx_done,
    output logic                       o_busy,
    output logic                       o_done
);

    state_t                     state, state_next;
    logic [UART_BITS-1:0]       word_cnt, word_cnt_next, word_cnt_dec;
    logic [DATA_ADDRS_BITS-1:0] addr, addr_next, addr_inc;

    logic                       mem_rd_next;
    logic [DATA_ADDRS_BITS-1:0] mem_addr_next;
    logic                       tx_start_next;
    logic [UART_BITS-1:0]       tx_data_next;
    logic                       busy_next;
    logic                       done_next;

    logic                       ser_clear;
    logic                       ser_load;
    logic                       ser_shift;
    logic [UART_BITS-1:0]       ser_next_byte;
    logic                       ser_last_byte;

    send_mem_fsm_serializer #(
        .DATA_BITS (DATA_BITS),
        .UART_BITS (UART_BITS)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .clear     (ser_clear),
        .load      (ser_load),
        .load_data (i_mem_data),
        .shift     (ser_shift),
        .next_byte (ser_next_byte),
        .last_byte (ser_last_byte)
    );

    // State, counters and every output are registered. The next-state logic
    // computes the output values for the state being entered, so each
    // output is already valid during the first cycle of its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_cnt   <= '0;
            addr       <= '0;
            o_mem_rd   <= 1'b0;
            o_mem_addr <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_next;
            word_cnt   <= word_cnt_next;
            addr       <= addr_next;
            o_mem_rd   <= mem_rd_next;
            o_mem_addr <= mem_addr_next;
            o_tx_start <= tx_start_next;
            o_tx_data  <= tx_data_next;
            o_busy     <= busy_next;
            o_done     <= done_next;
        end
    end

    // Next-state and next-output logic. Pulses default low and held values
    // default to their current register, so a state only spells out what
    // it changes. i_tx_done is consulted only in the two wait states, and
    // i_start only in IDLE.
    always_comb begin
        state_next    = state;
        word_cnt_next = word_cnt;
        addr_next     = addr;
        mem_rd_next   = 1'b0;
        mem_addr_next = o_mem_addr;
        tx_start_next = 1'b0;
        tx_data_next  = o_tx_data;
        busy_next     = o_busy;
        done_next     = 1'b0;
        ser_clear     = 1'b0;
        ser_load      = 1'b0;
        ser_shift     = 1'b0;
        word_cnt_dec  = word_cnt - 1'b1;
        addr_inc      = addr + 1'b1;

        case (state)
            IDLE: begin
                if (i_start) begin
                    word_cnt_next = i_word_count;
                    addr_next     = '0;
                    ser_clear     = 1'b1;
                    tx_start_next = 1'b1;
                    tx_data_next  = i_word_count;
                    busy_next     = 1'b1;
                    state_next    = SEND_COUNT;
                end
            end

            SEND_COUNT: begin
                state_next = WAIT_COUNT;
            end

            WAIT_COUNT: begin
                if (i_tx_done) begin
                    if (word_cnt != '0) begin
                        mem_rd_next   = 1'b1;
                        mem_addr_next = addr;
                        state_next    = READ_MEM;
                    end else begin
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = FINISH;
                    end
                end
            end

            READ_MEM: begin
                state_next = CAPTURE;
            end

            CAPTURE: begin
                ser_load      = 1'b1;
                tx_start_next = 1'b1;
                tx_data_next  = i_mem_data[DATA_BITS-1 -: UART_BITS];
                state_next    = SEND_BYTE;
            end

            SEND_BYTE: begin
                state_next = WAIT_BYTE;
            end

            WAIT_BYTE: begin
                if (i_tx_done) begin
                    ser_shift = 1'b1;
                    if (ser_last_byte) begin
                        addr_next     = addr_inc;
                        word_cnt_next = word_cnt_dec;
                        if (word_cnt_dec != '0) begin
                            mem_rd_next   = 1'b1;
                            mem_addr_next = addr_inc;
                            state_next    = READ_MEM;
                        end else begin
                            done_next  = 1'b1;
                            busy_next  = 1'b0;
                            state_next = FINISH;
                        end
                    end else begin
                        tx_start_next = 1'b1;
                        tx_data_next  = ser_next_byte;
                        state_next    = SEND_BYTE;
                    end
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_send_mem_fsm.sv
// tb_send_mem_fsm
// Scoreboard bench for send_mem_fsm. Each frame pushes its expected bytes
// (with the expected gap after the previous i_tx_done) and read addresses;
// a monitor pops and compares whenever the DUT strobes o_tx_start,
// o_mem_rd or o_done. A UART model answers every o_tx_start with i_tx_done
// after tx_delay cycles, and a memory model returns mem[o_mem_addr].

module tb_send_mem_fsm;

    typedef struct {
        logic [7:0] b;
        int         gap;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [7:0]  i_word_count;
    logic        o_mem_rd;
    logic [9:0]  o_mem_addr;
    logic [31:0] i_mem_data;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        i_tx_done;
    logic        o_busy;
    logic        o_done;

    logic        model_done;
    logic        spur_idle;
    logic        spur_rd;
    logic        inject_rd_spur;
    bit          model_busy;
    int          tx_delay;

    logic [31:0] mem [0:1023];
    exp_t        exp_q[$];
    int          addr_q[$];

    int          total;
    int          bad;
    int          cyc;
    int          last_done_cyc;
    int          sent_bytes;
    int          done_count;
    bit          tx_pending;
    bit          stable_ok;
    logic [7:0]  held;

    assign i_tx_done = model_done | spur_idle | spur_rd;

    send_mem_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_word_count (i_word_count),
        .o_mem_rd     (o_mem_rd),
        .o_mem_addr   (o_mem_addr),
        .i_mem_data   (i_mem_data),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .i_tx_done    (i_tx_done),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison goes through here so the counters stay honest
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pushByte(input logic [7:0] b, input int gap);
        exp_t e;
        e.b   = b;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Push a whole frame from the bench memory image: count byte, then
    // four bytes per word; the first byte of each word follows a 3-cycle
    // read/capture gap, the others follow a 1-cycle gap.
    task automatic pushFrame(input int count);
        logic [31:0] w;
        pushByte(8'(count), 0);
        for (int a = 0; a < count; a++) begin
            w = mem[a];
            addr_q.push_back(a);
            pushByte(w[31:24], 3);
            pushByte(w[23:16], 1);
            pushByte(w[15:8], 1);
            pushByte(w[7:0], 1);
        end
    endtask

    task automatic waitModelIdle();
        int budget;
        budget = 0;
        while ((model_busy || i_tx_done) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("model_idle_wait", 32'(budget < 200), 32'd1);
    endtask

    // Start a dump and wait (bounded) for its o_done. Optional stray
    // i_tx_done alongside the start, and an optional mid-frame restart
    // request with a different count.
    task automatic applyStimulus(input logic [7:0] count, input int delay,
                                 input bit stray_done, input bit mid_start);
        int d0;
        int b0;
        int budget;
        bit mid_sent;
        waitModelIdle();
        d0       = done_count;
        b0       = sent_bytes;
        mid_sent = 1'b0;
        tx_delay = delay;
        @(negedge clk);
        i_word_count = count;
        i_start      = 1'b1;
        spur_idle    = stray_done;
        @(negedge clk);
        i_start   = 1'b0;
        spur_idle = 1'b0;
        budget    = 0;
        while (done_count == d0 && budget < 12000) begin
            @(negedge clk);
            budget++;
            if (mid_start && !mid_sent && sent_bytes >= b0 + 2) begin
                i_word_count = 8'd7;
                i_start      = 1'b1;
                @(negedge clk);
                i_start  = 1'b0;
                mid_sent = 1'b1;
            end
        end
        repeat (5) @(negedge clk);
        checkOutput("done_count", 32'(done_count - d0), 32'd1);
        checkOutput("bytes_sent", 32'(sent_bytes - b0), 32'(1 + 4 * int'(count)));
        checkOutput("busy_after", 32'(o_busy), 32'd0);
    endtask

    // UART model: i_tx_done pulses tx_delay cycles after each o_tx_start.
    // The while re-checks o_tx_start on the same edge the done pulse ends,
    // so back-to-back bytes are not missed.
    initial begin
        model_done = 1'b0;
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            while (o_tx_start && !rst) begin
                model_busy = 1'b1;
                repeat (tx_delay) @(negedge clk);
                model_done = 1'b1;
                @(negedge clk);
                model_done = 1'b0;
                model_busy = 1'b0;
            end
        end
    end

    // Memory model: data appears the cycle after the read strobe
    initial begin
        i_mem_data = '0;
        forever begin
            @(negedge clk);
            if (o_mem_rd) i_mem_data = mem[o_mem_addr];
        end
    end

    // Stray i_tx_done injector, fires during the first READ_MEM when armed
    initial begin
        spur_rd = 1'b0;
        forever begin
            @(negedge clk);
            spur_rd = 1'b0;
            if (inject_rd_spur && o_mem_rd) begin
                spur_rd = 1'b1;
            end
        end
    end

    // Monitor: samples 1 ns after each rising edge and checks against the
    // scoreboard queues. Reset flushes the expectations of the aborted frame.
    initial begin
        exp_t e;
        cyc           = 0;
        last_done_cyc = 0;
        sent_bytes    = 0;
        done_count    = 0;
        tx_pending    = 1'b0;
        stable_ok     = 1'b1;
        held          = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                exp_q.delete();
                addr_q.delete();
                tx_pending = 1'b0;
            end else begin
                if (tx_pending && !i_tx_done && o_tx_data !== held) stable_ok = 1'b0;
                if (tx_pending && !i_tx_done && o_tx_start) begin
                    checkOutput("tx_start_before_done", 32'(o_tx_start), 32'd0);
                end
                if (i_tx_done && tx_pending) begin
                    checkOutput("tx_data_stable", 32'(stable_ok), 32'd1);
                    tx_pending    = 1'b0;
                    last_done_cyc = cyc;
                end
                if (o_tx_start) begin
                    sent_bytes++;
                    if (exp_q.size() == 0) begin
                        checkOutput("tx_unexpected", 32'(o_tx_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("tx_byte", 32'(o_tx_data), 32'(e.b));
                        if (e.gap != 0) checkOutput("tx_gap", 32'(cyc - last_done_cyc + 1), 32'(e.gap));
                    end
                    checkOutput("busy_in_frame", 32'(o_busy), 32'd1);
                    tx_pending = 1'b1;
                    held       = o_tx_data;
                    stable_ok  = 1'b1;
                end
                if (o_mem_rd) begin
                    if (addr_q.size() == 0) begin
                        checkOutput("mem_rd_unexpected", 32'(o_mem_addr), 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("mem_addr", 32'(o_mem_addr), 32'(addr_q.pop_front()));
                    end
                end
                if (o_done) begin
                    done_count++;
                    checkOutput("done_latency", 32'(cyc - last_done_cyc + 1), 32'd1);
                    checkOutput("frame_left", 32'(exp_q.size()), 32'd0);
                    checkOutput("reads_left", 32'(addr_q.size()), 32'd0);
                    checkOutput("busy_at_done", 32'(o_busy), 32'd0);
                end
            end
        end
    end

    // Directed test sequence
    initial begin
        int budget;
        int b_rst;
        int d_rst;
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        i_start        = 1'b0;
        i_word_count   = '0;
        spur_idle      = 1'b0;
        inject_rd_spur = 1'b0;
        tx_delay       = 10;
        for (int a = 0; a < 1024; a++) mem[a] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_mem_rd", 32'(o_mem_rd), 32'd0);
        checkOutput("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        checkOutput("rst_tx_start", 32'(o_tx_start), 32'd0);
        checkOutput("rst_tx_data", 32'(o_tx_data), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Zero count: single byte 0x00, no memory read
        $display("[TB] zero-count frame");
        pushByte(8'h00, 0);
        applyStimulus(8'd0, 10, 1'b0, 1'b0);

        // Two words with hand-computed byte stream
        $display("[TB] two-word frame");
        mem[0] = 32'hDEADBEEF;
        mem[1] = 32'h01234567;
        pushByte(8'h02, 0);
        addr_q.push_back(0);
        pushByte(8'hDE, 3); pushByte(8'hAD, 1); pushByte(8'hBE, 1); pushByte(8'hEF, 1);
        addr_q.push_back(1);
        pushByte(8'h01, 3); pushByte(8'h23, 1); pushByte(8'h45, 1); pushByte(8'h67, 1);
        applyStimulus(8'd2, 3, 1'b0, 1'b0);

        // Slow UART: data must hold and gaps stay exact
        $display("[TB] slow handshake frame");
        pushFrame(2);
        applyStimulus(8'd2, 50, 1'b0, 1'b0);

        // Stray done with start, stray done during READ_MEM, restart mid-frame
        $display("[TB] spurious inputs frame");
        pushFrame(2);
        inject_rd_spur = 1'b1;
        applyStimulus(8'd2, 4, 1'b1, 1'b1);
        inject_rd_spur = 1'b0;

        // Asynchronous reset during WAIT_BYTE
        $display("[TB] reset mid-frame");
        waitModelIdle();
        pushFrame(2);
        tx_delay = 20;
        @(negedge clk);
        i_word_count = 8'd2;
        i_start      = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        budget  = 0;
        while (sent_bytes < 3 + 1 + 8 + 9 + 9 + 3 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("reach_wait_byte", 32'(budget < 2000), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        b_rst = sent_bytes;
        d_rst = done_count;
        #1;
        checkOutput("async_rst_busy", 32'(o_busy), 32'd0);
        checkOutput("async_rst_tx_data", 32'(o_tx_data), 32'd0);
        checkOutput("async_rst_tx_start", 32'(o_tx_start), 32'd0);
        checkOutput("async_rst_mem_rd", 32'(o_mem_rd), 32'd0);
        checkOutput("async_rst_mem_addr", 32'(o_mem_addr), 32'd0);
        checkOutput("async_rst_done", 32'(o_done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        waitModelIdle();
        repeat (20) @(negedge clk);
        checkOutput("no_tx_after_rst", 32'(sent_bytes - b_rst), 32'd0);
        checkOutput("no_done_after_rst", 32'(done_count - d_rst), 32'd0);

        // Normal frame after the reset
        $display("[TB] frame after reset");
        pushByte(8'h01, 0);
        addr_q.push_back(0);
        pushByte(8'hDE, 3); pushByte(8'hAD, 1); pushByte(8'hBE, 1); pushByte(8'hEF, 1);
        applyStimulus(8'd1, 2, 1'b0, 1'b0);

        // Maximum count with mem[a] = a
        $display("[TB] max-count frame");
        for (int a = 0; a < 1024; a++) mem[a] = 32'(a);
        pushFrame(255);
        applyStimulus(8'd255, 1, 1'b0, 1'b0);
        checkOutput("final_mem_addr", 32'(o_mem_addr), 32'd254);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
